// File: rtl/pc_unit_pkg.sv
// Command encoding shared by the program counter and its producers in decode/branch logic.
package pc_cmd;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    INC  = 3'd1,
    LOAD = 3'd2,
    REL  = 3'd3,
    CALL = 3'd4,
    RET  = 3'd5
  } cmd;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam logic [PtrW:0] CountFull = (PtrW + 1)'(RAS_DEPTH);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PtrW-1:0]  ptr_q;
  logic [PtrW:0]    count_q;

  // ptr_q addresses the next free slot; when full that is also the oldest entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (push) begin
      ptr_q <= ptr_q + PtrW'(1);
      if (count_q != CountFull) count_q <= count_q + (PtrW + 1)'(1);
    end else if (pop) begin
      ptr_q   <= ptr_q - PtrW'(1);
      count_q <= count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) mem_q[ptr_q] <= push_data;
  end

  assign top   = mem_q[ptr_q - PtrW'(1)];
  assign empty = (count_q == '0);
  assign full  = (count_q == CountFull);

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with branch/call/return and error reporting.
// Define PC_UNIT_TRAP_EN to redirect faults to TRAP_VEC instead of hold/force-align.
module pc_unit #(
  parameter int unsigned     WIDTH     = 32,
  parameter int unsigned     STEP      = 4,
  parameter int unsigned     RAS_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'('h100)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  pc_cmd::cmd       cmd,
  input  logic [WIDTH-1:0] load_pc,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] pc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             err,
  output logic             trap
);

`ifdef PC_UNIT_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  localparam logic [WIDTH-1:0] StepW     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] AlignMask = WIDTH'(STEP - 1);

  logic [WIDTH-1:0] pc_q, pc_d, target, ras_top;
  logic             err_q, err_d, trap_q, trap_d;
  logic             push, pop, misaligned;

  pc_ras #(
    .WIDTH    (WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_data(pc_q + StepW),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );

  assign target     = (cmd == pc_cmd::REL) ? pc_q + offset : load_pc;
  assign misaligned = |(target & AlignMask);

  always_comb begin
    pc_d   = pc_q;
    err_d  = err_q;
    trap_d = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    unique case (cmd)
      pc_cmd::INC: pc_d = pc_q + StepW;
      pc_cmd::LOAD, pc_cmd::REL, pc_cmd::CALL: begin
        pc_d = target & ~AlignMask;
        push = (cmd == pc_cmd::CALL);
        if (misaligned) begin
          err_d = 1'b1;
          if (TrapEn) begin
            pc_d   = TRAP_VEC;
            trap_d = 1'b1;
            push   = 1'b0;
          end
        end
      end
      pc_cmd::RET: begin
        if (ras_empty) begin
          err_d = 1'b1;
          if (TrapEn) begin
            pc_d   = TRAP_VEC;
            trap_d = 1'b1;
          end
        end else begin
          pc_d = ras_top;
          pop  = 1'b1;
        end
      end
      default: ;
    endcase
    // Stall freezes everything, including the RAS.
    if (stall) begin
      pc_d   = pc_q;
      err_d  = err_q;
      trap_d = 1'b0;
      push   = 1'b0;
      pop    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      err_q  <= 1'b0;
      trap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      err_q  <= err_d;
      trap_q <= trap_d;
    end
  end

  assign pc   = pc_q;
  assign err  = err_q;
  assign trap = trap_q;

endmodule
